// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch lap timer.
//   sw_state_e      : controller state, encoded as seen on state_o
//   CS_PER_SEC/MIN  : centisecond scaling constants
//   MAX_CS_DEFAULT  : 59:59.99 expressed in centiseconds
//   led_spot()      : one-hot running-spot pattern for a centisecond count
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_RECALL = 2'd3
  } sw_state_e;

  localparam int CS_PER_SEC     = 100;
  localparam int CS_PER_MIN     = 6000;
  localparam int MAX_CS_DEFAULT = 59 * CS_PER_MIN + 59 * CS_PER_SEC + 99;

  // Seconds digit d = (cs / 100) % 10 lights led[9-d], so the spot walks
  // from the left-most LED to the right-most once every ten seconds.
  function automatic logic [9:0] led_spot(input logic [31:0] cs);
    logic [31:0] digit;
    digit = (cs / 32'(CS_PER_SEC)) % 32'd10;
    return 10'b10_0000_0000 >> digit;
  endfunction

endpackage

// File: rtl/sw_prescaler.sv
// Centisecond prescaler.
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : count enable; when low the count holds its value
//   clr        : synchronous clear to 0, wins over en
//   tick       : high for the cycle in which the count equals TICK_DIV-1
//                while enabled (suppressed during clr)
module sw_prescaler #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch with RUN/PAUSE/RECALL control, lap memory and lap-hold display.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   start_stop_p    : start from IDLE, otherwise stop and clear everything
//   pause_p         : RUN<->PAUSE, or leave RECALL back to PAUSE
//   lap_p           : capture the running count into lap memory (RUN only)
//   recall_p        : enter RECALL from PAUSE, then step through stored laps
//   time_display    : registered display value in centiseconds
//   lap_index       : lap shown in RECALL, else next write slot (saturated)
//   lap_count       : stored laps, 0..LAP_DEPTH
//   lap_full        : sticky, a lap was dropped because memory was full
//   state_o         : controller state (IDLE=0 RUN=1 PAUSE=2 RECALL=3)
//   led             : registered running-spot indicator
//   wrap_p          : one-cycle pulse aligned with the counter reading 0
//                     after a wrap from MAX_CS
// Input contract: every *_p input is a one-cycle pulse from the key edge
// stage; there is no backpressure. When several arrive in the same cycle
// only the highest-priority one acts:
// start_stop_p > pause_p > lap_p > recall_p.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 500000,
  parameter int MAX_CS    = MAX_CS_DEFAULT,
  parameter int TW        = 19,
  parameter int LAP_DEPTH = 8,
  parameter int HOLD_CS   = 200,
  parameter int LW        = $clog2(LAP_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_stop_p,
  input  logic          pause_p,
  input  logic          lap_p,
  input  logic          recall_p,
  output logic [TW-1:0] time_display,
  output logic [LW-1:0] lap_index,
  output logic [LW:0]   lap_count,
  output logic          lap_full,
  output logic [1:0]    state_o,
  output logic [9:0]    led,
  output logic          wrap_p
);

  localparam int            HW        = (HOLD_CS > 0) ? $clog2(HOLD_CS + 1) : 1;
  localparam logic [TW-1:0] MAX_V     = TW'(MAX_CS);
  localparam logic [LW:0]   DEPTH_V   = (LW + 1)'(LAP_DEPTH);
  localparam logic [HW-1:0] HOLD_V    = HW'(HOLD_CS);
  localparam logic [LW-1:0] LAST_SLOT = LW'(LAP_DEPTH - 1);

  sw_state_e     state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] latch_q, latch_d;
  logic [TW-1:0] disp_q, disp_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [LW:0]   lap_count_q, lap_count_d;
  logic [LW-1:0] recall_idx_q, recall_idx_d;
  logic          lap_full_q, lap_full_d;
  logic          wrap_q, wrap_d;
  logic [9:0]    led_q, led_d;

  logic [TW-1:0] lap_mem [LAP_DEPTH];
  logic          mem_we;
  logic [LW-1:0] mem_waddr;

  logic tick;
  logic ss_go, pause_go, lap_go, recall_go;

  // Priority decode: a higher pulse masks all lower ones in its cycle.
  assign ss_go     = start_stop_p;
  assign pause_go  = pause_p  & ~start_stop_p;
  assign lap_go    = lap_p    & ~start_stop_p & ~pause_p;
  assign recall_go = recall_p & ~start_stop_p & ~pause_p & ~lap_p;

  // The prescaler only runs in RUN and keeps its phase across a pause.
  sw_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_RUN),
    .clr   (ss_go),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ss_go) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ss_go)         state_d = ST_IDLE;
        else if (pause_go) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (ss_go)                                      state_d = ST_IDLE;
        else if (pause_go)                              state_d = ST_RUN;
        else if (recall_go && (lap_count_q != '0))      state_d = ST_RECALL;
      end
      ST_RECALL: begin
        if (ss_go)         state_d = ST_IDLE;
        else if (pause_go) state_d = ST_PAUSE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next values: counter, hold timer, laps, recall index
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    latch_d      = latch_q;
    lap_count_d  = lap_count_q;
    lap_full_d   = lap_full_q;
    recall_idx_d = recall_idx_q;
    wrap_d       = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = lap_count_q[LW-1:0];

    if (ss_go) begin
      // Leaving for IDLE clears everything; entering RUN from IDLE finds
      // these already clear, so the clear is applied unconditionally.
      cnt_d        = '0;
      hold_d       = '0;
      latch_d      = '0;
      lap_count_d  = '0;
      lap_full_d   = 1'b0;
      recall_idx_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick) begin
            cnt_d  = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
            wrap_d = (cnt_q == MAX_V);
            if (hold_q != '0) hold_d = hold_q - 1'b1;
          end
          // The lap captures this cycle's count; a reload of the hold
          // timer overrides a decrement from a coincident tick.
          if (lap_go) begin
            if (lap_count_q < DEPTH_V) begin
              mem_we      = 1'b1;
              lap_count_d = lap_count_q + 1'b1;
            end else begin
              lap_full_d = 1'b1;
            end
            hold_d  = HOLD_V;
            latch_d = cnt_q;
          end
        end
        ST_PAUSE: begin
          if (recall_go && (lap_count_q != '0)) recall_idx_d = '0;
        end
        ST_RECALL: begin
          if (recall_go) begin
            recall_idx_d = ({1'b0, recall_idx_q} == lap_count_q - 1'b1)
                           ? '0 : recall_idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: registered outputs (display and LED spot)
  // ---------------------------------------------------------------------
  always_comb begin
    disp_d = '0;
    led_d  = '0;
    case (state_q)
      ST_IDLE: begin
        disp_d = '0;
        led_d  = '0;
      end
      ST_RECALL: begin
        disp_d = lap_mem[recall_idx_q];
        led_d  = led_spot(32'(cnt_q));
      end
      default: begin
        disp_d = (hold_q != '0) ? latch_q : cnt_q;
        led_d  = led_spot(32'(cnt_q));
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      hold_q       <= '0;
      latch_q      <= '0;
      lap_count_q  <= '0;
      lap_full_q   <= 1'b0;
      recall_idx_q <= '0;
      wrap_q       <= 1'b0;
      disp_q       <= '0;
      led_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      latch_q      <= latch_d;
      lap_count_q  <= lap_count_d;
      lap_full_q   <= lap_full_d;
      recall_idx_q <= recall_idx_d;
      wrap_q       <= wrap_d;
      disp_q       <= disp_d;
      led_q        <= led_d;
    end
  end

  // Lap storage has no reset; lap_count bounds which entries are valid.
  // state_q is IDLE throughout reset, so no write can happen then.
  always_ff @(posedge clk) begin
    if (mem_we) lap_mem[mem_waddr] <= cnt_q;
  end

  assign time_display = disp_q;
  assign led          = led_q;
  assign wrap_p       = wrap_q;
  assign state_o      = state_q;
  assign lap_count    = lap_count_q;
  assign lap_full     = lap_full_q;
  assign lap_index    = (state_q == ST_RECALL) ? recall_idx_q
                      : (lap_count_q >= DEPTH_V) ? LAST_SLOT
                      : lap_count_q[LW-1:0];

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Two stopwatch instances share one stimulus stream:
//   a: TICK_DIV=4, default MAX_CS, LAP_DEPTH=2, HOLD_CS=3
//   b: TICK_DIV=2, MAX_CS=9,       LAP_DEPTH=4, HOLD_CS=2
// A behavioural model per instance is checked every cycle, alongside a
// hand-derived vector table and directed corner-case sequences.
module tb_stopwatch_lap_timer;

  localparam int A_DIV = 4, A_MAX = 359999, A_TW = 19, A_DEPTH = 2, A_HOLD = 3;
  localparam int B_DIV = 2, B_MAX = 9,      B_TW = 4,  B_DEPTH = 4, B_HOLD = 2;

  // ------------------------------------------------------------------
  // Clock / reset / DUTs
  // ------------------------------------------------------------------
  logic clk;
  logic rst_n;
  logic ss, pz, lp, rc;

  logic [A_TW-1:0] a_disp;
  logic [0:0]      a_li;
  logic [1:0]      a_lc;
  logic            a_full;
  logic [1:0]      a_state;
  logic [9:0]      a_led;
  logic            a_wrap;

  logic [B_TW-1:0] b_disp;
  logic [1:0]      b_li;
  logic [2:0]      b_lc;
  logic            b_full;
  logic [1:0]      b_state;
  logic [9:0]      b_led;
  logic            b_wrap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stopwatch_lap_timer #(
    .TICK_DIV (A_DIV), .MAX_CS (A_MAX), .TW (A_TW),
    .LAP_DEPTH (A_DEPTH), .HOLD_CS (A_HOLD)
  ) dut_a (
    .clk (clk), .rst_n (rst_n),
    .start_stop_p (ss), .pause_p (pz), .lap_p (lp), .recall_p (rc),
    .time_display (a_disp), .lap_index (a_li), .lap_count (a_lc),
    .lap_full (a_full), .state_o (a_state), .led (a_led), .wrap_p (a_wrap)
  );

  stopwatch_lap_timer #(
    .TICK_DIV (B_DIV), .MAX_CS (B_MAX), .TW (B_TW),
    .LAP_DEPTH (B_DEPTH), .HOLD_CS (B_HOLD)
  ) dut_b (
    .clk (clk), .rst_n (rst_n),
    .start_stop_p (ss), .pause_p (pz), .lap_p (lp), .recall_p (rc),
    .time_display (b_disp), .lap_index (b_li), .lap_count (b_lc),
    .lap_full (b_full), .state_o (b_state), .led (b_led), .wrap_p (b_wrap)
  );

  // ------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: mode 0=IDLE 1=RUN 2=PAUSE 3=RECALL
  // ------------------------------------------------------------------
  int p_div[2]   = '{A_DIV, B_DIV};
  int p_max[2]   = '{A_MAX, B_MAX};
  int p_depth[2] = '{A_DEPTH, B_DEPTH};
  int p_hold[2]  = '{A_HOLD, B_HOLD};

  int m_mode[2], m_pre[2], m_cnt[2], m_hold[2], m_latch[2];
  int m_n[2], m_idx[2], m_full[2];
  int m_disp[2], m_led[2], m_wrap[2];
  int m_laps[2][8];

  task automatic model_reset(input int k);
    m_mode[k] = 0; m_pre[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_latch[k] = 0;
    m_n[k] = 0; m_idx[k] = 0; m_full[k] = 0;
    m_disp[k] = 0; m_led[k] = 0; m_wrap[k] = 0;
  endtask

  // One clock edge; pl = {start_stop, pause, lap, recall}.
  task automatic model_step(input int k, input logic [3:0] pl);
    int old_cnt;
    bit tk;
    // Display and LED reflect the situation before this edge.
    m_disp[k] = (m_mode[k] == 0) ? 0
              : (m_mode[k] == 3) ? m_laps[k][m_idx[k]]
              : ((m_hold[k] > 0) ? m_latch[k] : m_cnt[k]);
    m_led[k]  = (m_mode[k] == 0) ? 0 : (1 << (9 - (m_cnt[k] / 100) % 10));
    m_wrap[k] = 0;
    if (pl[3]) begin
      if (m_mode[k] == 0) begin
        m_mode[k] = 1;
        m_pre[k]  = 0;
      end else begin
        m_mode[k] = 0; m_cnt[k] = 0; m_pre[k] = 0; m_hold[k] = 0;
        m_n[k] = 0; m_full[k] = 0; m_idx[k] = 0;
      end
    end else if (m_mode[k] == 1) begin
      old_cnt = m_cnt[k];
      tk = 0;
      if (m_pre[k] == p_div[k] - 1) begin
        m_pre[k] = 0;
        tk = 1;
      end else begin
        m_pre[k] = m_pre[k] + 1;
      end
      if (tk) begin
        if (m_cnt[k] == p_max[k]) begin
          m_cnt[k]  = 0;
          m_wrap[k] = 1;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
        if (m_hold[k] > 0) m_hold[k] = m_hold[k] - 1;
      end
      if (pl[2]) begin
        m_mode[k] = 2;
      end else if (pl[1]) begin
        if (m_n[k] < p_depth[k]) begin
          m_laps[k][m_n[k]] = old_cnt;
          m_n[k] = m_n[k] + 1;
        end else begin
          m_full[k] = 1;
        end
        m_hold[k]  = p_hold[k];
        m_latch[k] = old_cnt;
      end
    end else if (m_mode[k] == 2) begin
      if (pl[2]) m_mode[k] = 1;
      else if (!pl[1] && pl[0] && m_n[k] > 0) begin
        m_mode[k] = 3;
        m_idx[k]  = 0;
      end
    end else if (m_mode[k] == 3) begin
      if (pl[2]) m_mode[k] = 2;
      else if (!pl[1] && pl[0]) m_idx[k] = (m_idx[k] + 1) % m_n[k];
    end
  endtask

  function automatic int exp_li(input int k);
    if (m_mode[k] == 3) return m_idx[k];
    return (m_n[k] < p_depth[k]) ? m_n[k] : p_depth[k] - 1;
  endfunction

  task automatic check_model();
    chk("a_disp",  int'(a_disp),  m_disp[0]);
    chk("a_li",    int'(a_li),    exp_li(0));
    chk("a_lc",    int'(a_lc),    m_n[0]);
    chk("a_full",  int'(a_full),  m_full[0]);
    chk("a_state", int'(a_state), m_mode[0]);
    chk("a_led",   int'(a_led),   m_led[0]);
    chk("a_wrap",  int'(a_wrap),  m_wrap[0]);
    chk("b_disp",  int'(b_disp),  m_disp[1]);
    chk("b_li",    int'(b_li),    exp_li(1));
    chk("b_lc",    int'(b_lc),    m_n[1]);
    chk("b_full",  int'(b_full),  m_full[1]);
    chk("b_state", int'(b_state), m_mode[1]);
    chk("b_led",   int'(b_led),   m_led[1]);
    chk("b_wrap",  int'(b_wrap),  m_wrap[1]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_disp"},  int'(a_disp),  0);
    chk({tag, "_a_li"},    int'(a_li),    0);
    chk({tag, "_a_lc"},    int'(a_lc),    0);
    chk({tag, "_a_state"}, int'(a_state), 0);
    chk({tag, "_a_led"},   int'(a_led),   0);
    chk({tag, "_b_disp"},  int'(b_disp),  0);
    chk({tag, "_b_lc"},    int'(b_lc),    0);
    chk({tag, "_b_full"},  int'(b_full),  0);
    chk({tag, "_b_state"}, int'(b_state), 0);
    chk({tag, "_b_wrap"},  int'(b_wrap),  0);
  endtask

  // ------------------------------------------------------------------
  // Driver: called at a falling edge; applies pulses for one cycle
  // ------------------------------------------------------------------
  task automatic drive(input logic [3:0] pl);
    {ss, pz, lp, rc} = pl;
    @(posedge clk);
    if (rst_n) begin
      model_step(0, pl);
      model_step(1, pl);
    end else begin
      model_reset(0);
      model_reset(1);
    end
    @(negedge clk);
    {ss, pz, lp, rc} = 4'b0000;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000);
  endtask

  task automatic run_until_a(input int target);
    int g;
    g = 0;
    while (m_cnt[0] != target && g < 2000) begin
      drive(4'b0000);
      g++;
    end
    chk("run_until_timeout", g, (g < 2000) ? g : 0);
  endtask

  // ------------------------------------------------------------------
  // Vector table for instance b (bits {ss,pz,lp,rc}); pulses on the
  // first of reps cycles, outputs compared after the last one.
  // ------------------------------------------------------------------
  typedef struct {
    logic [3:0] pl;
    int         reps;
    int         st;
    int         disp;
    int         wrap;
    int         lc;
    int         li;
  } vec_t;

  vec_t tbl[28];

  localparam logic [3:0] SS = 4'b1000, PZ = 4'b0100, LP = 4'b0010, RC = 4'b0001, NO = 4'b0000;

  initial begin
    tbl[0]  = '{SS,      1, 1, 0, 0, 0, 0};
    tbl[1]  = '{NO,     19, 1, 9, 0, 0, 0};
    tbl[2]  = '{NO,      1, 1, 9, 1, 0, 0};  // 9 -> 0 wrap
    tbl[3]  = '{NO,      1, 1, 0, 0, 0, 0};
    tbl[4]  = '{NO,      1, 1, 0, 0, 0, 0};
    tbl[5]  = '{PZ,      1, 2, 1, 0, 0, 0};  // prescaler frozen at 1
    tbl[6]  = '{NO,      5, 2, 1, 0, 0, 0};
    tbl[7]  = '{PZ,      1, 1, 1, 0, 0, 0};
    tbl[8]  = '{NO,      1, 1, 1, 0, 0, 0};  // tick on first RUN cycle
    tbl[9]  = '{NO,      1, 1, 2, 0, 0, 0};
    tbl[10] = '{LP,      1, 1, 2, 0, 1, 1};  // lap of 2, coincident tick
    tbl[11] = '{NO,      1, 1, 2, 0, 1, 1};
    tbl[12] = '{NO,      1, 1, 2, 0, 1, 1};
    tbl[13] = '{NO,      2, 1, 2, 0, 1, 1};
    tbl[14] = '{NO,      1, 1, 5, 0, 1, 1};  // hold expired, live again
    tbl[15] = '{PZ,      1, 2, 5, 0, 1, 1};
    tbl[16] = '{RC,      1, 3, 6, 0, 1, 0};
    tbl[17] = '{NO,      1, 3, 2, 0, 1, 0};
    tbl[18] = '{RC,      1, 3, 2, 0, 1, 0};  // single lap wraps to 0
    tbl[19] = '{SS,      1, 0, 2, 0, 0, 0};
    tbl[20] = '{NO,      1, 0, 0, 0, 0, 0};
    tbl[21] = '{SS,      1, 1, 0, 0, 0, 0};
    tbl[22] = '{PZ,      1, 2, 0, 0, 0, 0};
    tbl[23] = '{RC,      1, 2, 0, 0, 0, 0};  // no laps: stay in PAUSE
    tbl[24] = '{PZ,      1, 1, 0, 0, 0, 0};
    tbl[25] = '{LP,      1, 1, 0, 0, 1, 1};
    tbl[26] = '{SS | LP, 1, 0, 0, 0, 0, 0};  // stop wins over lap
    tbl[27] = '{NO,      1, 0, 0, 0, 0, 0};
  end

  // ------------------------------------------------------------------
  // Test sequence
  // ------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    {ss, pz, lp, rc} = 4'b0000;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Table vectors, instance b
    for (int i = 0; i < 28; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) drive((r == 0) ? tbl[i].pl : NO);
      chk($sformatf("tbl%0d_state", i), int'(b_state), tbl[i].st);
      chk($sformatf("tbl%0d_disp", i),  int'(b_disp),  tbl[i].disp);
      chk($sformatf("tbl%0d_wrap", i),  int'(b_wrap),  tbl[i].wrap);
      chk($sformatf("tbl%0d_lc", i),    int'(b_lc),    tbl[i].lc);
      chk($sformatf("tbl%0d_li", i),    int'(b_li),    tbl[i].li);
    end

    // One second and two seconds on instance a (TICK_DIV=4)
    drive(SS);
    idle(401);
    chk("sec1_disp", int'(a_disp), 100);
    chk("sec1_led",  int'(a_led),  10'b0100000000);
    idle(400);
    chk("sec2_disp", int'(a_disp), 200);
    chk("sec2_led",  int'(a_led),  10'b0010000000);

    // Lap hold on instance a: lap at 50, held for 3 ticks, live at 53
    drive(SS);
    drive(SS);
    run_until_a(50);
    drive(LP);
    idle(2);
    chk("hold_disp50", int'(a_disp), 50);
    run_until_a(53);
    idle(1);
    chk("hold_live53", int'(a_disp), 53);
    chk("hold_lc",     int'(a_lc),   1);
    drive(PZ);
    drive(RC);
    idle(1);
    chk("hold_mem0", int'(a_disp), 50);

    // Lap memory full on instance a (depth 2)
    drive(SS);
    drive(SS);
    run_until_a(10); drive(LP);
    run_until_a(20); drive(LP);
    run_until_a(30); drive(LP);
    chk("full_lc",   int'(a_lc),   2);
    chk("full_flag", int'(a_full), 1);
    drive(PZ);
    drive(RC); idle(1);
    chk("rcl0_disp", int'(a_disp), 10);
    chk("rcl0_li",   int'(a_li),   0);
    drive(RC); idle(1);
    chk("rcl1_disp", int'(a_disp), 20);
    chk("rcl1_li",   int'(a_li),   1);
    drive(RC); idle(1);
    chk("rcl2_disp", int'(a_disp), 10);
    chk("rcl2_li",   int'(a_li),   0);

    // Asynchronous reset in the middle of RUN, with pulses held high
    drive(SS);
    drive(SS);
    idle(30);
    drive(LP);
    #2;
    rst_n = 1'b0;
    ss = 1'b1;
    lp = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    @(negedge clk);
    check_zero("in_rst");
    rst_n = 1'b1;
    {ss, pz, lp, rc} = 4'b0000;
    idle(3);

    // Randomised pulses against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] pl;
      pl[3] = ($urandom_range(0, 79) == 0);
      pl[2] = ($urandom_range(0, 11) == 0);
      pl[1] = ($urandom_range(0, 9) == 0);
      pl[0] = ($urandom_range(0, 5) == 0);
      drive(pl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_timer.md
Name: stopwatch_lap_timer

Overview:
Parametrised successor of the single-channel stopwatch controller. It is fully synchronous, with a centisecond prescaler, a RUN/PAUSE/RECALL state machine, and a lap memory of LAP_DEPTH entries. After each lap capture the display holds the lap time for HOLD_CS centiseconds, then returns to the live count. It sits between the key debounce/edge stage and the sevenseg decimal formatter.

Parameters:
TICK_DIV, 500000, clk cycles per centisecond (50 MHz default); must be >= 2
MAX_CS, 359999, last count value before wrap to 0 (59:59.99)
TW, 19, time width; must be >= $clog2(MAX_CS+1)
LAP_DEPTH, 8, lap memory entries (power of two, >= 2)
HOLD_CS, 200, centiseconds the display holds a captured lap; 0 disables hold
LW, $clog2(LAP_DEPTH), lap index width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_stop_p  in  1  single-cycle pulse: start, or stop and clear
pause_p  in  1  single-cycle pulse: pause/resume, or exit recall
lap_p  in  1  single-cycle pulse: capture lap (RUN only)
recall_p  in  1  single-cycle pulse: enter recall / step lap index
time_display  out  TW  value for the sevenseg formatter, in centiseconds
lap_index  out  LW  lap currently shown in RECALL, otherwise the next write slot
lap_count  out  LW+1  number of stored laps, 0..LAP_DEPTH
lap_full  out  1  sticky; a lap was dropped because memory was full
state_o  out  2  IDLE=0, RUN=1, PAUSE=2, RECALL=3
led  out  10  running-spot indicator
wrap_p  out  1  single-cycle pulse when the counter wraps MAX_CS to 0

Behaviour:
- Reset (async assert, sync release): state IDLE; counter, prescaler, time_display, lap_index, lap_count, hold timer = 0; lap_full=0; led=0; wrap_p=0. Lap memory contents are don't-care.
- Pulse priority within one cycle: start_stop_p > pause_p > lap_p > recall_p. Lower-priority pulses in the same cycle are ignored.
- IDLE:
  - start_stop_p -> RUN, with prescaler=0.
  - Other pulses are ignored.
  - time_display=0.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. A tick occurs on the cycle it equals TICK_DIV-1, and the prescaler returns to 0.
  - On a tick: counter = (counter==MAX_CS) ? 0 : counter+1. wrap_p=1 in the same cycle as the 0 load.
  - pause_p -> PAUSE.
  - start_stop_p -> IDLE: clear counter, prescaler, laps, lap_full, hold.
  - lap_p: if lap_count<LAP_DEPTH, write the counter value of this cycle to mem[lap_count] and increment lap_count; otherwise set lap_full and do not write. Either way load hold = HOLD_CS and latch the captured value for display.
- PAUSE:
  - Prescaler and counter are frozen; the prescaler keeps its value, so resume is phase-accurate.
  - pause_p -> RUN.
  - recall_p with lap_count>0 -> RECALL, lap_index=0.
  - recall_p with lap_count==0 is ignored.
  - lap_p is ignored.
- RECALL:
  - Counter is frozen.
  - recall_p: lap_index = (lap_index==lap_count-1) ? 0 : lap_index+1.
  - pause_p -> PAUSE.
  - start_stop_p -> IDLE with full clear.
- time_display is registered, updating 1 cycle after the source changes.
  - IDLE: 0.
  - RECALL: mem[lap_index].
  - RUN/PAUSE: the latched lap value while hold>0, else counter.
- Hold timer decrements on ticks only; it is frozen in PAUSE. A new lap_p during a hold reloads HOLD_CS and the new value.
- lap_index outside RECALL equals lap_count (saturated to LAP_DEPTH-1).
- led: RUN/PAUSE/RECALL give a one-hot 1<<(9 - (counter/100)%10); IDLE gives 0. This is registered.
- Reset mid-operation aborts everything immediately; there is no partial lap write.

Decomposition:
- Shared package stopwatch_pkg holds:
  - the state enum (IDLE/RUN/PAUSE/RECALL, 2 bits);
  - CS_PER_SEC=100, CS_PER_MIN=6000 and the default MAX_CS;
  - the led spot function.
- One sub-module, sw_prescaler: counts TICK_DIV with enable and clear and outputs the tick.
- Lap memory stays inline as a register array.

Test Plan:
- TICK_DIV=4: reset, start_stop_p, wait 400 cycles -> time_display=100, led=10'b0100000000; a further 400 cycles -> 200.
- MAX_CS=9, TICK_DIV=2: run 20 cycles -> counter steps 9 to 0 with one wrap_p pulse in that cycle; pause at prescaler=1, resume -> next tick exactly 1 cycle later.
- HOLD_CS=3, TICK_DIV=4: lap_p at count 50 -> display 50 for 3 ticks, then live 53; lap_count=1, mem[0]=50.
- LAP_DEPTH=2: three lap_p at 10/20/30 -> lap_count=2, lap_full=1; pause, recall_p x3 -> display 10, 20, 10 with lap_index 0, 1, 0.
- Same-cycle start_stop_p+lap_p in RUN -> IDLE, lap_count=0, lap_full=0, display 0; recall_p in PAUSE with no laps -> stays PAUSE.
- rst_n low mid-RUN for 1 cycle (async, off clock edge) -> all outputs 0 immediately, state IDLE; pulses during reset are ignored.
